sram_dp_wp2_131072x64: RTL and testbench

//  Behavioural true dual-port SRAM: 131072 words x 64 bits, two independent ports (A, B) on one clock.

---
 rtl/sram_dp_wp2_131072x64_pkg.sv | 12 +
 rtl/sram_dp_wp2_131072x64_if.sv | 20 ++
 rtl/sram_dp_wp2_131072x64_merge.sv | 19 +
 rtl/sram_dp_wp2_131072x64.sv | 63 ++++++
 tb/tb_sram_dp_wp2_131072x64.sv | 134 +++++++++++++
 5 files changed

// File: rtl/sram_dp_wp2_131072x64_pkg.sv
// Shared constants and types for the dual-port 131072x64 half-word-masked SRAM.
package sram_pkg;
   localparam int unsigned DEPTH  = 131072;
   localparam int unsigned ADDR_W = 17;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned NWM    = 2;
   localparam int unsigned HALF_W = 32;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [NWM-1:0]    wmask_t;
endpackage

// File: rtl/sram_dp_wp2_131072x64_if.sv
// Port bundle for both SRAM ports; master drives requests, slave returns Q.
interface sram_dp_wp2_131072x64_if;
   import sram_pkg::*;

   logic   CENA;
   wmask_t WENA;
   addr_t  AA;
   word_t  DA;
   word_t  QA;
   logic   CENB;
   wmask_t WENB;
   addr_t  AB;
   word_t  DB;
   word_t  QB;

   modport master (output CENA, WENA, AA, DA, CENB, WENB, AB, DB,
                   input  QA, QB);
   modport slave  (input  CENA, WENA, AA, DA, CENB, WENB, AB, DB,
                   output QA, QB);
endinterface

// File: rtl/sram_dp_wp2_131072x64_merge.sv
// Combinational half-word merge: each active-low mask bit replaces its half of old with d.
module sram_wp2_merge
   import sram_pkg::*;
(
   input  word_t  old_w,
   input  word_t  d,
   input  wmask_t wen,
   output word_t  new_w
);

   // Start from the stored word and overwrite the enabled halves.
   always_comb begin
      new_w = old_w;
      for (int unsigned i = 0; i < NWM; i++) begin
         if (!wen[i]) new_w[i*HALF_W +: HALF_W] = d[i*HALF_W +: HALF_W];
      end
   end

endmodule

// File: rtl/sram_dp_wp2_131072x64.sv
// Behavioural true dual-port SRAM, 131072 x 64, per-half active-low write masks,
// registered write-through read data.
// Build option: SRAM_ZERO_INIT_EN zero-fills the array at time zero (default: X).
module sram_dp_wp2_131072x64
   import sram_pkg::*;
(
   input  logic                          CLK,
   input  logic                          RST,
   sram_dp_wp2_131072x64_if.slave        bus
);

`ifdef SRAM_ZERO_INIT_EN
   word_t mem [DEPTH] = '{default: '0};
`else
   word_t mem [DEPTH];
`endif

   word_t old_a, old_b, base_a, merge_a, merge_b;
   logic  wr_a, wr_b, coll;

   // Decode port activity and detect a same-address access from both ports.
   always_comb begin
      wr_a  = !bus.CENA && (bus.WENA != '1);
      wr_b  = !bus.CENB && (bus.WENB != '1);
      coll  = !bus.CENA && !bus.CENB && (bus.AA == bus.AB);
      old_a = mem[bus.AA];
      old_b = mem[bus.AB];
   end

   // On collision port A merges on top of port B's result, so A wins any shared
   // half while disjoint halves from both ports survive in one merged word.
   always_comb begin
      base_a = coll ? merge_b : old_a;
   end

   sram_wp2_merge u_merge_b (
      .old_w (old_b),
      .d     (bus.DB),
      .wen   (bus.WENB),
      .new_w (merge_b)
   );

   sram_wp2_merge u_merge_a (
      .old_w (base_a),
      .d     (bus.DA),
      .wen   (bus.WENA),
      .new_w (merge_a)
   );

   // Array update and Q registers; reset clears Q and blocks writes but leaves the array.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bus.QA <= '0;
         bus.QB <= '0;
      end else begin
         if (wr_a || (coll && wr_b)) mem[bus.AA] <= merge_a;
         if (wr_b && !coll)          mem[bus.AB] <= merge_b;
         if (!bus.CENA) bus.QA <= merge_a;
         if (!bus.CENB) bus.QB <= coll ? merge_a : merge_b;
      end
   end

endmodule

// File: tb/tb_sram_dp_wp2_131072x64.sv
// Directed self-checking bench for sram_dp_wp2_131072x64.
module tb_sram_dp_wp2_131072x64;
   import sram_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   ntests = 0;
   int   nfail  = 0;

   sram_dp_wp2_131072x64_if bus ();

   sram_dp_wp2_131072x64 dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic port_a(input logic cen, input logic [1:0] wen, input logic [16:0] a, input logic [63:0] d);
      bus.CENA = cen; bus.WENA = wen; bus.AA = a; bus.DA = d;
   endtask

   task automatic port_b(input logic cen, input logic [1:0] wen, input logic [16:0] a, input logic [63:0] d);
      bus.CENB = cen; bus.WENB = wen; bus.AB = a; bus.DB = d;
   endtask

   initial begin
      rst = 1'b1;
      port_a(1'b1, 2'b11, 17'd0, 64'h0);
      port_b(1'b1, 2'b11, 17'd0, 64'h0);
      edge_step();
      check("reset_qa", bus.QA, 64'h0);
      check("reset_qb", bus.QB, 64'h0);
      rst = 1'b0;

      // 1: full write on A, low-half write on B
      port_a(1'b0, 2'b00, 17'd0, 64'h00001111_00002222);
      port_b(1'b0, 2'b10, 17'd1, 64'h00003333_00004444);
      edge_step();
      check("t1_qa", bus.QA, 64'h00001111_00002222);
      check("t1_qb_lo", {32'h0, bus.QB[31:0]}, 64'h00000000_00004444);

      // 2: upper-half write on A, low-half on B
      port_a(1'b0, 2'b01, 17'd0, 64'h0000AAAA_0000BBBB);
      port_b(1'b0, 2'b10, 17'd1, 64'h0000CCCC_0000DDDD);
      edge_step();
      check("t2_qa", bus.QA, 64'h0000AAAA_00002222);
      check("t2_qb_lo", {32'h0, bus.QB[31:0]}, 64'h00000000_0000DDDD);

      // 3: complementary halves
      port_a(1'b0, 2'b10, 17'd0, 64'h0000AAAA_0000BBBB);
      port_b(1'b0, 2'b01, 17'd1, 64'h0000CCCC_0000DDDD);
      edge_step();
      check("t3_qa", bus.QA, 64'h0000AAAA_0000BBBB);
      check("t3_qb", bus.QB, 64'h0000CCCC_0000DDDD);

      // 4: reads with fresh D values must not disturb memory
      port_a(1'b0, 2'b11, 17'd0, 64'hDEADBEEF_DEADBEEF);
      port_b(1'b0, 2'b11, 17'd1, 64'hCAFEF00D_CAFEF00D);
      edge_step();
      check("t4_qa", bus.QA, 64'h0000AAAA_0000BBBB);
      check("t4_qb", bus.QB, 64'h0000CCCC_0000DDDD);
      port_a(1'b0, 2'b11, 17'd1, 64'h0);
      port_b(1'b0, 2'b11, 17'd0, 64'h0);
      edge_step();
      check("t4_cross_qa", bus.QA, 64'h0000CCCC_0000DDDD);
      check("t4_cross_qb", bus.QB, 64'h0000AAAA_0000BBBB);

      // 5: collision, both write upper half -> A wins; A also writes lower
      port_a(1'b0, 2'b00, 17'd5, 64'h00001111_00002222);
      port_b(1'b0, 2'b01, 17'd5, 64'h00003333_00004444);
      edge_step();
      check("t5_qa", bus.QA, 64'h00001111_00002222);
      check("t5_qb", bus.QB, 64'h00001111_00002222);

      // collision, disjoint halves -> both land
      port_a(1'b0, 2'b10, 17'd6, 64'h00005555_00006666);
      port_b(1'b0, 2'b01, 17'd6, 64'h00007777_00008888);
      edge_step();
      check("t5_disj_qa", bus.QA, 64'h00007777_00006666);
      check("t5_disj_qb", bus.QB, 64'h00007777_00006666);

      // collision, A reads while B writes low -> both see B's write
      port_a(1'b0, 2'b11, 17'd6, 64'hFFFFFFFF_FFFFFFFF);
      port_b(1'b0, 2'b10, 17'd6, 64'h0000EEEE_00009999);
      edge_step();
      check("t5_rdwr_qa", bus.QA, 64'h00007777_00009999);
      check("t5_rdwr_qb", bus.QB, 64'h00007777_00009999);

      // 6: reset with write requests pending -> Q cleared, no write
      rst = 1'b1;
      port_a(1'b0, 2'b00, 17'd0, 64'h12345678_9ABCDEF0);
      port_b(1'b0, 2'b00, 17'd5, 64'h0FEDCBA9_87654321);
      edge_step();
      check("t6_rst_qa", bus.QA, 64'h0);
      check("t6_rst_qb", bus.QB, 64'h0);
      rst = 1'b0;
      port_a(1'b0, 2'b11, 17'd0, 64'h0);
      port_b(1'b0, 2'b11, 17'd5, 64'h0);
      edge_step();
      check("t6_post_qa", bus.QA, 64'h0000AAAA_0000BBBB);
      check("t6_post_qb", bus.QB, 64'h00001111_00002222);

      // chip disabled with write mask active -> Q holds, memory untouched
      port_a(1'b1, 2'b00, 17'd0, 64'hFFFFFFFF_FFFFFFFF);
      port_b(1'b1, 2'b00, 17'd6, 64'hFFFFFFFF_FFFFFFFF);
      edge_step();
      check("t6_hold_qa", bus.QA, 64'h0000AAAA_0000BBBB);
      check("t6_hold_qb", bus.QB, 64'h00001111_00002222);
      port_a(1'b0, 2'b11, 17'd0, 64'h0);
      port_b(1'b0, 2'b11, 17'd6, 64'h0);
      edge_step();
      check("t6_nowr_qa", bus.QA, 64'h0000AAAA_0000BBBB);
      check("t6_nowr_qb", bus.QB, 64'h00007777_00009999);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
